// File: rtl/coin_detector.sv
// Purpose: synchronise and debounce three coin buttons, report one strobe per clean single-button press.
// Latency: DEBOUNCE_CYCLES+3 edges from first raw sample to c (2 sync + debounce + output register).
// Backpressure: none; inh_i refuses coins (reject_o pulse), a holds the last accepted value.
module coin_detector #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int VAL_W           = 8,
    parameter int COIN0_VAL       = 25,
    parameter int COIN1_VAL       = 50,
    parameter int COIN2_VAL       = 100
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       coin_btn_i,
    input  logic             inh_i,
    output logic             c,
    output logic [VAL_W-1:0] a,
    output logic             reject_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [VAL_W-1:0] VAL0 = VAL_W'(COIN0_VAL);
    localparam logic [VAL_W-1:0] VAL1 = VAL_W'(COIN1_VAL);
    localparam logic [VAL_W-1:0] VAL2 = VAL_W'(COIN2_VAL);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [CNT_W-1:0] cnt;
    state_t           state_q;
    state_t           state_d;
    logic             c_d;
    logic             rej_d;
    logic [VAL_W-1:0] a_d;
    logic [VAL_W-1:0] coin_val;

    // The whole vector is debounced as one word, so a multi-button press settles together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= coin_btn_i;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        coin_val = '0;
        if (stable[0]) begin
            coin_val = VAL0;
        end else if (stable[1]) begin
            coin_val = VAL1;
        end else if (stable[2]) begin
            coin_val = VAL2;
        end
    end

    // A press is judged once, on the IDLE exit; anything else seen before full release is ignored.
    always_comb begin
        state_d = state_q;
        c_d     = 1'b0;
        rej_d   = 1'b0;
        a_d     = a;
        case (state_q)
            IDLE: begin
                if (stable != 3'b000) begin
                    state_d = WAIT_REL;
                    if (($countones(stable) == 1) && !inh_i) begin
                        c_d = 1'b1;
                        a_d = coin_val;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                if (stable == 3'b000) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            c        <= 1'b0;
            reject_o <= 1'b0;
            a        <= '0;
        end else begin
            state_q  <= state_d;
            c        <= c_d;
            reject_o <= rej_d;
            a        <= a_d;
        end
    end

endmodule
